mem_port: RTL

Memory-side partner of the multi-cycle RV32 core. It owns a single-port synchronous word SRAM and turns the core's byte-addressed `mem_read`/`mem_wren`/`mem_size` requests into word accesses with byte enables, load alignment and sign/zero extension. It also arbitrates a host loader port and sequences the core's boot: it holds the core in reset while the host fills memory, then fetches the reset vector that the core samples during reset.

---
 rtl/mem_port_pkg.sv | 77 +++++++
 rtl/mem_port_load_align.sv | 14 +
 rtl/mem_port.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mem_port_pkg.sv
// mem_port shared types and helpers.
// Size encodings, boot states, byte-lane and extend functions.
package mem_port_pkg;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_addr_t;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_VEC,
    ST_HOLD,
    ST_RUN
  } mport_state_t;

  function automatic logic [3:0] store_be(
    input mem_addr_t  size,
    input logic [1:0] off
  );
    logic [3:0] be;
    case (size)
      MEM_B, MEM_BU: be = 4'b0001 << off;
      MEM_H, MEM_HU: be = off[1] ? 4'b1100 : 4'b0011;
      default:       be = 4'hF;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_data(
    input mem_addr_t   size,
    input logic [31:0] d
  );
    logic [31:0] w;
    case (size)
      MEM_B, MEM_BU: w = {4{d[7:0]}};
      MEM_H, MEM_HU: w = {2{d[15:0]}};
      default:       w = d;
    endcase
    return w;
  endfunction

  function automatic logic misaligned(
    input mem_addr_t  size,
    input logic [1:0] off
  );
    logic m;
    case (size)
      MEM_B, MEM_BU: m = 1'b0;
      MEM_H, MEM_HU: m = off[0];
      default:       m = |off;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] load_ext(
    input logic [31:0] word,
    input mem_addr_t   size,
    input logic [1:0]  off
  );
    logic [31:0] sh;
    logic [31:0] r;
    sh = word >> {off, 3'b000};
    case (size)
      MEM_B:   r = {{24{sh[7]}}, sh[7:0]};
      MEM_H:   r = {{16{sh[15]}}, sh[15:0]};
      MEM_BU:  r = {24'b0, sh[7:0]};
      MEM_HU:  r = {16'b0, sh[15:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_port_load_align.sv
// Load return path.
// Moves the addressed byte/half to bit 0 and extends it.
module load_align
  import mem_port_pkg::*;
(
  input  logic [31:0] word_i,
  input  mem_addr_t   size_i,
  input  logic [1:0]  off_i,
  output logic [31:0] data_o
);

  assign data_o = load_ext(word_i, size_i, off_i);

endmodule

// File: rtl/mem_port.sv
// Core-side memory port with host loader and boot sequencer.
// Owns the SRAM request path and the core reset.
module mem_port
  import mem_port_pkg::*;
#(
  parameter int          AW             = 12,
  parameter logic [31:0] RESET_VEC_ADDR = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_read,
  input  logic          mem_wren,
  input  logic [31:0]   mem_addr,
  input  mem_addr_t     mem_size,
  input  logic [31:0]   memwrite_data,
  output logic [31:0]   memread_data,
  output logic          core_rst,
  output logic          misalign,
  input  logic          host_valid,
  output logic          host_ready,
  input  logic [AW-1:0] host_addr,
  input  logic [31:0]   host_wdata,
  input  logic          host_go,
  input  logic          host_halt,
  output logic          sram_en,
  output logic [3:0]    sram_we,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata
);

  mport_state_t state_q, state_d;
  logic         misalign_q, misalign_d;
  logic         rd_vld_q, rd_vld_d;
  logic         rd_zero_q, rd_zero_d;
  logic [1:0]   rd_off_q, rd_off_d;
  mem_addr_t    rd_size_q, rd_size_d;
  logic [31:0]  rdata_q;
  logic [31:0]  aligned;
  logic [31:0]  ret;
  logic         req_mis;
  logic         unused_addr;

  assign unused_addr = ^mem_addr[31:AW+2];
  assign req_mis     = misaligned(mem_size, mem_addr[1:0]);

  load_align u_align (
    .word_i (sram_rdata),
    .size_i (rd_size_q),
    .off_i  (rd_off_q),
    .data_o (aligned)
  );

  assign ret          = rd_vld_q ? (rd_zero_q ? 32'h0 : aligned)
                                 : rdata_q;
  assign memread_data = ret;
  assign misalign     = misalign_q;

  // Boot sequencing and request steering to the SRAM.
  always_comb begin
    state_d    = state_q;
    misalign_d = misalign_q;
    rd_vld_d   = 1'b0;
    rd_zero_d  = 1'b0;
    rd_off_d   = rd_off_q;
    rd_size_d  = rd_size_q;
    core_rst   = 1'b1;
    host_ready = 1'b0;
    sram_en    = 1'b0;
    sram_we    = 4'h0;
    sram_addr  = mem_addr[AW+1:2];
    sram_wdata = store_data(mem_size, memwrite_data);
    unique case (state_q)
      ST_LOAD: begin
        host_ready = 1'b1;
        if (host_valid) begin
          sram_en    = 1'b1;
          sram_we    = 4'hF;
          sram_addr  = host_addr;
          sram_wdata = host_wdata;
        end
        if (host_go) state_d = ST_VEC;
      end
      ST_VEC: begin
        sram_en   = 1'b1;
        sram_addr = RESET_VEC_ADDR[AW+1:2];
        rd_vld_d  = 1'b1;
        rd_off_d  = 2'b00;
        rd_size_d = MEM_W;
        state_d   = ST_HOLD;
      end
      ST_HOLD: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        core_rst = 1'b0;
        if (host_halt) begin
          state_d = ST_LOAD;
        end else if (mem_wren) begin
          if (req_mis) begin
            misalign_d = 1'b1;
          end else begin
            sram_en = 1'b1;
            sram_we = store_be(mem_size, mem_addr[1:0]);
          end
        end else if (mem_read) begin
          rd_vld_d  = 1'b1;
          rd_off_d  = mem_addr[1:0];
          rd_size_d = mem_size;
          if (req_mis) begin
            misalign_d = 1'b1;
            rd_zero_d  = 1'b1;
          end else begin
            sram_en = 1'b1;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // State, sticky flag, load tracking and the read holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_LOAD;
      misalign_q <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_zero_q  <= 1'b0;
      rd_off_q   <= 2'b00;
      rd_size_q  <= MEM_W;
      rdata_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      misalign_q <= misalign_d;
      rd_vld_q   <= rd_vld_d;
      rd_zero_q  <= rd_zero_d;
      rd_off_q   <= rd_off_d;
      rd_size_q  <= rd_size_d;
      rdata_q    <= ret;
    end
  end

endmodule
